// File: rtl/pwm_bank_pkg.sv
// Shared register-map constants for the pwm_bank PWM peripheral.
package pwm_bank_pkg;

  localparam int MAX_CHANNELS = 32;

  localparam logic [7:0] ADDR_EN_OUT_BASE = 8'h00;
  localparam logic [7:0] ADDR_EN_PWM_BASE = 8'h04;
  localparam logic [7:0] ADDR_PRESCALE    = 8'h08;
  localparam logic [7:0] ADDR_DUTY_BASE   = 8'h20;

endpackage

// File: rtl/pwm_bank_timebase.sv
// Prescaler and period counter for pwm_bank; generates tick and period_start.
// The wrap output exists only when PWM_BANK_SHADOW_EN is defined.
module pwm_bank_timebase #(
  parameter int DUTY_W = 8,
  parameter int PRE_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PRE_W-1:0]  prescale,
  output logic [DUTY_W-1:0] cnt,
`ifdef PWM_BANK_SHADOW_EN
  output logic              wrap,
`endif
  output logic              period_start
);

  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [DUTY_W-1:0] cnt_q, cnt_d;
  logic              started_q, started_d;
  logic              ps_q, ps_d;
  logic              tick;
  logic              wrap_now;

  always_comb begin
    // NOTE: every output of a combinational block is given a default first, so no path can infer a latch.
    tick      = (pre_q == prescale);
    wrap_now  = tick && (&cnt_q);
    // A prescaler count already above a newly lowered PRESCALE runs on to its maximum and rolls over.
    pre_d     = pre_q + 1'b1;
    cnt_d     = cnt_q;
    started_d = started_q | tick;
    if (tick) begin
      pre_d = '0;
      cnt_d = cnt_q + 1'b1;
    end
    ps_d = wrap_now || (tick && !started_q);
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      started_q <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      ps_q      <= ps_d;
    end
  end

  assign cnt          = cnt_q;
  assign period_start = ps_q;
`ifdef PWM_BANK_SHADOW_EN
  assign wrap = wrap_now;
`endif

endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with per-channel enables/duty behind a byte-wide register port.
// Define PWM_BANK_SHADOW_EN to give each duty register a shadow loaded only at the period wrap.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int CHANNELS = 16,
  parameter int DUTY_W   = 8,
  parameter int PRE_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [7:0]          wr_addr,
  input  logic [7:0]          wr_data,
  input  logic [7:0]          rd_addr,
  output logic [7:0]          rd_data,
  output logic                period_start,
  output logic [CHANNELS-1:0] out
);

  logic [PRE_W-1:0]        prescale_q, prescale_d;
  logic [DUTY_W-1:0]       cnt;
  logic [MAX_CHANNELS-1:0] en_out_all, en_pwm_all;
  logic [7:0]              duty_all [MAX_CHANNELS];
  logic [7:0]              rd_data_q, rd_data_d;
`ifdef PWM_BANK_SHADOW_EN
  logic                    wrap;
`endif

  pwm_bank_timebase #(
    .DUTY_W (DUTY_W),
    .PRE_W  (PRE_W)
  ) u_timebase (
    .clk          (clk),
    .rst          (rst),
    .prescale     (prescale_q),
    .cnt          (cnt),
`ifdef PWM_BANK_SHADOW_EN
    .wrap         (wrap),
`endif
    .period_start (period_start)
  );

  always_comb begin
    prescale_d = prescale_q;
    if (wr_en && wr_addr == ADDR_PRESCALE) prescale_d = wr_data[PRE_W-1:0];
  end

  for (genvar ch = 0; ch < MAX_CHANNELS; ch++) begin : g_ch
    if (ch < CHANNELS) begin : g_live
      localparam logic [7:0] ADDR_OUT  = ADDR_EN_OUT_BASE + 8'(ch / 8);
      localparam logic [7:0] ADDR_PWM  = ADDR_EN_PWM_BASE + 8'(ch / 8);
      localparam logic [7:0] ADDR_DUTY = ADDR_DUTY_BASE + 8'(ch);
      localparam int         BIT       = ch % 8;

      logic              en_out_q, en_out_d;
      logic              en_pwm_q, en_pwm_d;
      logic              out_q, out_d;
      logic              pwm;
      logic [DUTY_W-1:0] duty_q, duty_d;
      logic [DUTY_W-1:0] act;

      always_comb begin
        en_out_d = en_out_q;
        en_pwm_d = en_pwm_q;
        duty_d   = duty_q;
        if (wr_en && wr_addr == ADDR_OUT)  en_out_d = wr_data[BIT];
        if (wr_en && wr_addr == ADDR_PWM)  en_pwm_d = wr_data[BIT];
        if (wr_en && wr_addr == ADDR_DUTY) duty_d   = wr_data[DUTY_W-1:0];
      end

`ifdef PWM_BANK_SHADOW_EN
      logic [DUTY_W-1:0] act_q, act_d;
      // A write coinciding with the wrap updates duty_q at the same edge, so act_q still takes the old value.
      always_comb act_d = wrap ? duty_q : act_q;
      assign act = act_q;
`else
      assign act = duty_q;
`endif

      always_comb begin
        pwm   = (act == '1) || (cnt < act);
        out_d = en_out_q && (!en_pwm_q || pwm);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          en_out_q <= 1'b0;
          en_pwm_q <= 1'b0;
          // NOTE: duty storage is a small per-channel register, not RAM, so it is reset like any other flop.
          duty_q   <= '0;
          out_q    <= 1'b0;
`ifdef PWM_BANK_SHADOW_EN
          act_q    <= '0;
`endif
        end else begin
          en_out_q <= en_out_d;
          en_pwm_q <= en_pwm_d;
          duty_q   <= duty_d;
          out_q    <= out_d;
`ifdef PWM_BANK_SHADOW_EN
          act_q    <= act_d;
`endif
        end
      end

      assign out[ch]        = out_q;
      assign en_out_all[ch] = en_out_q;
      assign en_pwm_all[ch] = en_pwm_q;
      assign duty_all[ch]   = 8'(duty_q);
    end else begin : g_pad
      // Channels beyond CHANNELS hold nothing and read back as zero.
      assign en_out_all[ch] = 1'b0;
      assign en_pwm_all[ch] = 1'b0;
      assign duty_all[ch]   = '0;
    end
  end

  always_comb begin
    rd_data_d = '0;
    if (rd_addr[7:2] == ADDR_EN_OUT_BASE[7:2]) begin
      rd_data_d = en_out_all[{rd_addr[1:0], 3'b000} +: 8];
    end else if (rd_addr[7:2] == ADDR_EN_PWM_BASE[7:2]) begin
      rd_data_d = en_pwm_all[{rd_addr[1:0], 3'b000} +: 8];
    end else if (rd_addr == ADDR_PRESCALE) begin
      rd_data_d = 8'(prescale_q);
    end else if (rd_addr[7:5] == ADDR_DUTY_BASE[7:5]) begin
      rd_data_d = duty_all[rd_addr[4:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale_q <= '0;
      rd_data_q  <= '0;
    end else begin
      prescale_q <= prescale_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: directed scenarios plus random register traffic,
// compared every cycle against a behavioural model of the register map and PWM rules.
module tb_pwm_bank;

  localparam int CH      = 16;
  localparam int DW      = 8;
  localparam int PW      = 8;
  localparam int CNT_MOD = 1 << DW;
  localparam int CNT_MAX = CNT_MOD - 1;
  localparam int PRE_MOD = 1 << PW;
`ifdef PWM_BANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_addr, wr_data, rd_addr;
  logic [7:0]    rd_data;
  logic          period_start;
  logic [CH-1:0] out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            m_en_out [32];
  int            m_en_pwm [32];
  int            m_duty   [32];
  int            m_act    [32];
  int            m_pre, m_pc, m_cnt;
  bit            m_started;
  logic [CH-1:0] m_out;
  logic          m_ps;
  logic [7:0]    m_rd;

  pwm_bank #(
    .CHANNELS (CH),
    .DUTY_W   (DW),
    .PRE_W    (PW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .period_start (period_start),
    .out          (out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_read(input int a);
    logic [7:0] r;
    r = '0;
    for (int b = 0; b < 8; b++) begin
      if (a <= 3 && 8 * a + b < CH) r[b] = (m_en_out[8 * a + b] != 0);
      if (a >= 4 && a <= 7 && 8 * (a - 4) + b < CH) r[b] = (m_en_pwm[8 * (a - 4) + b] != 0);
    end
    if (a == 8) r = 8'(m_pre);
    if (a >= 32 && a < 32 + CH) r = 8'(m_duty[a - 32]);
    return r;
  endfunction

  function automatic void model_write(input int a, input logic [7:0] d);
    for (int b = 0; b < 8; b++) begin
      if (a <= 3 && 8 * a + b < CH) m_en_out[8 * a + b] = int'(d[b]);
      if (a >= 4 && a <= 7 && 8 * (a - 4) + b < CH) m_en_pwm[8 * (a - 4) + b] = int'(d[b]);
    end
    if (a == 8) m_pre = int'(d) % PRE_MOD;
    if (a >= 32 && a < 32 + CH) m_duty[a - 32] = int'(d) % CNT_MOD;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit            tick, wrap, level;
    int            act;
    logic [CH-1:0] o;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_en_out[i] = 0;
        m_en_pwm[i] = 0;
        m_duty[i]   = 0;
        m_act[i]    = 0;
      end
      m_pre = 0; m_pc = 0; m_cnt = 0; m_started = 1'b0;
      m_out = '0; m_ps = 1'b0; m_rd = '0;
    end else begin
      tick = (m_pc == m_pre);
      wrap = tick && (m_cnt == CNT_MAX);
      for (int c = 0; c < CH; c++) begin
        act   = SHADOW ? m_act[c] : m_duty[c];
        level = (act == CNT_MAX) || (m_cnt < act);
        o[c]  = (m_en_out[c] != 0) ? ((m_en_pwm[c] != 0) ? level : 1'b1) : 1'b0;
      end
      m_out = o;
      m_ps  = tick && (wrap || !m_started);
      m_rd  = model_read(int'(rd_addr));
      m_pc  = tick ? 0 : (m_pc + 1) % PRE_MOD;
      if (tick) begin
        m_cnt     = (m_cnt + 1) % CNT_MOD;
        m_started = 1'b1;
      end
      if (wrap) for (int c = 0; c < 32; c++) m_act[c] = m_duty[c];
      if (wr_en) model_write(int'(wr_addr), wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and compare all outputs with the model on the falling edge.
  task automatic step();
    @(negedge clk);
    check("out", 32'(out), 32'(m_out));
    check("period_start", 32'(period_start), 32'(m_ps));
    check("rd_data", 32'(rd_data), 32'(m_rd));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_ps(input int limit);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < limit);
    check("wait_ps_timeout", 32'(period_start), 32'd1);
  endtask

  // Starts on a period_start sample; counts high samples of channels 0..2 until the next one.
  task automatic measure(input int wr_at, input logic [7:0] wa, input logic [7:0] wd,
                         output int hi0, output int hi1, output int hi2, output int len);
    hi0 = 0; hi1 = 0; hi2 = 0; len = 0;
    do begin
      hi0 += int'(out[0]);
      hi1 += int'(out[1]);
      hi2 += int'(out[2]);
      if (len == wr_at) begin
        wr_en = 1'b1; wr_addr = wa; wr_data = wd;
      end
      step();
      wr_en = 1'b0;
      len++;
    end while (period_start !== 1'b1 && len < 5000);
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 8'($urandom_range(0, 7));
      1:       return 8'h08;
      2, 3:    return 8'(32 + $urandom_range(0, 31));
      4:       return 8'($urandom_range(9, 31));
      default: return 8'($urandom_range(64, 255));
    endcase
  endfunction

  initial begin
    int h0, h1, h2, len;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    repeat (3) step();
    rst = 1'b0;

    // Reset mid-operation clears everything immediately
    wr(8'h00, 8'h0F); wr(8'h04, 8'h0F); wr(8'h20, 8'h55); wr(8'h21, 8'hAA);
    rd_addr = 8'h20;
    repeat (100) step();
    #2 rst = 1'b1;
    #1;
    check("reset_out", 32'(out), 32'd0);
    check("reset_rd_data", 32'(rd_data), 32'd0);
    check("reset_period_start", 32'(period_start), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    step(); step();
    check("reset_duty0_readback", 32'(rd_data), 32'h00);

    // Static enable: out[0] high from N+2, out[1] stays low
    wr(8'h00, 8'h01); wr(8'h04, 8'h00);
    for (int i = 0; i < 20; i++) begin
      check("static_out0", 32'(out[0]), 32'd1);
      check("static_out1", 32'(out[1]), 32'd0);
      step();
    end

    // 50% duty, PRESCALE = 0
    wr(8'h08, 8'h00); wr(8'h20, 8'h80); wr(8'h04, 8'h01);
    wait_ps(600);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    check("duty50_high", 32'(h0), 32'd128);
    check("duty50_period", 32'(len), 32'd256);

    // Duty extremes on channel 1, two full periods each
    wr(8'h00, 8'h07); wr(8'h04, 8'h07); wr(8'h21, 8'h00); wr(8'h22, 8'h40);
    wait_ps(600);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    for (int p = 0; p < 2; p++) begin
      measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
      check("duty_zero_high", 32'(h1), 32'd0);
    end
    wr(8'h21, 8'hFF);
    wait_ps(600);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    for (int p = 0; p < 2; p++) begin
      measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
      check("duty_full_high", 32'(h1), 32'd256);
      check("duty_full_period", 32'(len), 32'd256);
    end

    // Prescaler = 3: 1024-cycle period
    wr(8'h08, 8'h03);
    wait_ps(3000);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    check("prescale_high_ch2", 32'(h2), 32'd256);
    check("prescale_high_ch0", 32'(h0), 32'd512);
    check("prescale_period", 32'(len), 32'd1024);

    // Mid-period duty change on channel 0 (0x80 -> 0x20 at sample 40)
    wr(8'h08, 8'h00);
    wait_ps(3000);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    measure(40, 8'h20, 8'h20, h0, h1, h2, len);
    check("midwrite_high", 32'(h0), SHADOW ? 32'd128 : 32'd41);
    check("midwrite_period", 32'(len), 32'd256);
    measure(-1, 8'h00, 8'h00, h0, h1, h2, len);
    check("after_write_high", 32'(h0), 32'd32);

    // Read-during-write returns old value; new value two cycles after the write
    rd_addr = 8'h23;
    step();
    check("rb_before", 32'(rd_data), 32'h00);
    wr_en = 1'b1; wr_addr = 8'h23; wr_data = 8'h5A;
    step();
    wr_en = 1'b0;
    check("rb_same_cycle_old", 32'(rd_data), 32'h00);
    step();
    check("rb_new", 32'(rd_data), 32'h5A);
    rd_addr = 8'h20; step();
    check("rb_duty0", 32'(rd_data), 32'h20);

    // Unstored channels and unmapped addresses
    wr(8'h02, 8'hFF); wr(8'h30, 8'h77); wr(8'h09, 8'h33); wr(8'h01, 8'hA5);
    rd_addr = 8'h02; step(); check("rb_en_out_hi_byte", 32'(rd_data), 32'h00);
    rd_addr = 8'h30; step(); check("rb_duty_unstored", 32'(rd_data), 32'h00);
    rd_addr = 8'h09; step(); check("rb_unmapped", 32'(rd_data), 32'h00);
    rd_addr = 8'h01; step(); check("rb_en_out_byte1", 32'(rd_data), 32'hA5);
    rd_addr = 8'h04; step(); check("rb_en_pwm_byte0", 32'(rd_data), 32'h07);
    rd_addr = 8'h08; step(); check("rb_prescale", 32'(rd_data), 32'h00);

    // Random register traffic with one asynchronous reset in the middle
    for (int i = 0; i < 2000; i++) begin
      rd_addr = rand_addr();
      if ($urandom_range(0, 9) < 3) begin
        wr_addr = rand_addr();
        wr_data = (wr_addr == 8'h08) ? 8'($urandom_range(0, 3)) : 8'($urandom);
        wr_en   = 1'b1;
      end
      if (i == 1000) rst = 1'b1;
      if (i == 1003) rst = 1'b0;
      step();
      wr_en = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
